// File: rtl/wishbone_master_n_pkg.sv
// wishbone_master_n_pkg: FSM states, default slave map and timeout shared by the bridge.
package wishbone_master_n_pkg;
  typedef enum logic [1:0] {WBM_IDLE, WBM_BUS, WBM_RESP} wbm_state_e;
  localparam int UART_IDX = 0;
  localparam int SPI_IDX = 1;
  localparam int PWM_IDX = 2;
  localparam logic [31:0] UART_BASE = 32'h2000_0000;
  localparam logic [31:0] SPI_BASE = 32'h2001_0000;
  localparam logic [31:0] PWM_BASE = 32'h2002_0000;
  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int SAYAC_W = 16;
endpackage

// File: rtl/wb_adres_cozucu.sv
// wb_adres_cozucu: slave-index field to one-hot select plus unmapped flag.
module wb_adres_cozucu
  import wishbone_master_n_pkg::*;
#(
  parameter int SLAVE_COUNT = 3,
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]       alan_i,
  output logic [SLAVE_COUNT-1:0] sec_o,
  output logic                   gecersiz_o
);
  for (genvar g = 0; g < SLAVE_COUNT; g++) begin : g_sec
    assign sec_o[g] = alan_i == SEL_W'(g);
  end
  assign gecersiz_o = {1'b0, alan_i} >= (SEL_W+1)'(SLAVE_COUNT);
endmodule

// File: rtl/wishbone_master_n.sv
// wishbone_master_n: data-bus to N-slave Wishbone B4 classic bridge.
// Define WB_TIMEOUT_EN to abort BUS cycles that go TIMEOUT_CYC cycles without ack.
module wishbone_master_n
  import wishbone_master_n_pkg::*;
#(
  parameter int SLAVE_COUNT = 3,
  parameter int SEL_LSB = 16,
  parameter int SEL_W = 2,
  parameter int ADR_W = 8,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               vy_adres_i,
  input  logic [31:0]               vy_veri_i,
  input  logic [3:0]                vy_veri_maske_i,
  input  logic                      vy_yaz_gecerli_i,
  input  logic                      vy_sec_i,
  output logic [31:0]               vy_veri_o,
  output logic                      vy_durdur_o,
  output logic                      vy_hata_o,
  output logic [ADR_W-1:0]          adr_o,
  output logic [31:0]               dat_o,
  output logic                      we_o,
  output logic [3:0]                sel_o,
  output logic                      stb_o,
  output logic [SLAVE_COUNT-1:0]    cyc_o,
  input  logic [SLAVE_COUNT-1:0]    ack_i,
  input  logic [32*SLAVE_COUNT-1:0] dat_i
);
  wbm_state_e state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d, veri_q, veri_d, okunan;
  logic [3:0] sel_q, sel_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SLAVE_COUNT-1:0] cyc_q, cyc_d, giris_sec, secili;
  logic we_q, we_d, stb_q, stb_d, hata_q, hata_d;
  logic giris_gecersiz, secili_gecersiz, ack_ok, zaman_asimi, unused_bits;
  // Live decode picks BUS vs RESP at acceptance; latched decode qualifies ack and read data.
  wb_adres_cozucu #(.SLAVE_COUNT(SLAVE_COUNT), .SEL_W(SEL_W)) u_giris (
    .alan_i(vy_adres_i[SEL_LSB +: SEL_W]), .sec_o(giris_sec), .gecersiz_o(giris_gecersiz)
  );
  wb_adres_cozucu #(.SLAVE_COUNT(SLAVE_COUNT), .SEL_W(SEL_W)) u_cozucu (
    .alan_i(idx_q), .sec_o(secili), .gecersiz_o(secili_gecersiz)
  );
  assign unused_bits = ^{vy_adres_i, 32'(TIMEOUT_CYC)};
  assign ack_ok = !secili_gecersiz && |(ack_i & secili);
  always_comb begin
    okunan = '0;
    for (int i = 0; i < SLAVE_COUNT; i++) okunan |= secili[i] ? dat_i[32*i +: 32] : 32'd0;
  end
`ifdef WB_TIMEOUT_EN
  logic [SAYAC_W-1:0] sayac_q, sayac_d;
  assign sayac_d = (state_q == WBM_BUS) ? sayac_q + 1'b1 : '0;
  assign zaman_asimi = sayac_d == SAYAC_W'(TIMEOUT_CYC);
  always_ff @(posedge clk_i) sayac_q <= rst_i ? '0 : sayac_d;
`else
  assign zaman_asimi = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    dat_d = dat_q;
    sel_d = sel_q;
    we_d = we_q;
    idx_d = idx_q;
    stb_d = stb_q;
    cyc_d = cyc_q;
    veri_d = veri_q;
    hata_d = hata_q;
    if (state_q == WBM_IDLE && vy_sec_i) begin
      adr_d = vy_adres_i[ADR_W-1:0];
      dat_d = vy_veri_i;
      sel_d = vy_veri_maske_i;
      we_d = vy_yaz_gecerli_i;
      idx_d = vy_adres_i[SEL_LSB +: SEL_W];
      state_d = giris_gecersiz ? WBM_RESP : WBM_BUS;
      stb_d = !giris_gecersiz;
      cyc_d = giris_gecersiz ? '0 : giris_sec;
      veri_d = giris_gecersiz ? '0 : veri_q;
      hata_d = giris_gecersiz ? 1'b1 : hata_q;
    end else if (state_q == WBM_BUS && (ack_ok || zaman_asimi)) begin
      state_d = WBM_RESP;
      stb_d = 1'b0;
      cyc_d = '0;
      veri_d = (ack_ok && !we_q) ? okunan : '0;
      hata_d = !ack_ok;
    end else if (state_q == WBM_RESP) begin
      state_d = WBM_IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WBM_IDLE;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      we_q <= 1'b0;
      idx_q <= '0;
      stb_q <= 1'b0;
      cyc_q <= '0;
      veri_q <= '0;
      hata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      sel_q <= sel_d;
      we_q <= we_d;
      idx_q <= idx_d;
      stb_q <= stb_d;
      cyc_q <= cyc_d;
      veri_q <= veri_d;
      hata_q <= hata_d;
    end
  end
  assign vy_durdur_o = (state_q == WBM_IDLE && vy_sec_i) || state_q == WBM_BUS;
  assign vy_veri_o = veri_q;
  assign vy_hata_o = hata_q;
  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign we_o = we_q;
  assign sel_o = sel_q;
  assign stb_o = stb_q;
  assign cyc_o = cyc_q;
endmodule
